// File: rtl/dataplane_axi_lite_regs.sv
// dataplane_axi_lite_regs: AXI4-Lite register bank (ID, CTRL, STATUS, RX_CNT, SCRATCH) for the dataplane
module dataplane_axi_lite_regs #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [3:0]        ctrl_o,
  input  logic [31:0]       status_i,
  input  logic              pkt_i
);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic live, aw_held, w_held, commit, ar_hs, clr, w_ok, w_ctrl, w_scr, rd_err;
  logic [ADDR_W-3:0] wa_q, ra;
  logic [DATA_W-1:0] wdata_q, bmask, scratch, rx_cnt, rd_data;
  logic [3:0] wstrb_q;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  // live holds the readies low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) live <= 1'b0;
    else live <= 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) w_state <= W_IDLE;
    else w_state <= w_next;
  always_comb
    w_next = (w_state == W_IDLE) ? ((aw_held && w_held) ? W_RESP : W_IDLE)
                                 : (s_axi_bready ? W_IDLE : W_RESP);
  always_comb begin
    s_axi_awready = live && w_state == W_IDLE && !aw_held;
    s_axi_wready  = live && w_state == W_IDLE && !w_held;
    s_axi_bvalid  = w_state == W_RESP;
    commit        = w_state == W_IDLE && aw_held && w_held;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      wa_q    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        wa_q    <= s_axi_awaddr[ADDR_W-1:2];
      end else if (commit) aw_held <= 1'b0;
      if (s_axi_wvalid && s_axi_wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end else if (commit) w_held <= 1'b0;
    end
  assign w_ctrl = wa_q == (ADDR_W-2)'(1);
  assign w_scr  = &wa_q;
  assign w_ok   = wa_q <= (ADDR_W-2)'(3) || w_scr;
  assign bmask  = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
  assign clr    = commit && w_ctrl && wstrb_q[3] && wdata_q[31];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl_o      <= '0;
      scratch     <= '0;
      rx_cnt      <= '0;
      s_axi_bresp <= 2'b00;
    end else begin
      if (commit && w_ctrl && wstrb_q[0]) ctrl_o <= wdata_q[3:0];
      if (commit && w_scr) scratch <= (scratch & ~bmask) | (wdata_q & bmask);
      if (commit) s_axi_bresp <= w_ok ? 2'b00 : 2'b10;
      rx_cnt <= clr ? '0 : rx_cnt + DATA_W'(pkt_i);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= R_IDLE;
    else r_state <= r_next;
  always_comb
    r_next = (r_state == R_IDLE) ? (ar_hs ? R_DATA : R_IDLE)
                                 : (s_axi_rready ? R_IDLE : R_DATA);
  always_comb begin
    s_axi_arready = live && r_state == R_IDLE;
    s_axi_rvalid  = r_state == R_DATA;
    ar_hs         = s_axi_arvalid && s_axi_arready;
  end
  assign ra = s_axi_araddr[ADDR_W-1:2];
  always_comb begin
    rd_data = (ra == (ADDR_W-2)'(0)) ? VERSION
            : (ra == (ADDR_W-2)'(1)) ? {28'd0, ctrl_o}
            : (ra == (ADDR_W-2)'(2)) ? status_i
            : (ra == (ADDR_W-2)'(3)) ? rx_cnt
            : (&ra)                  ? scratch
            : 32'hDEAD_BEEF;
    rd_err  = !(ra <= (ADDR_W-2)'(3) || &ra);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
    end else if (ar_hs) begin
      s_axi_rdata <= rd_data;
      s_axi_rresp <= rd_err ? 2'b10 : 2'b00;
    end
endmodule

// File: tb/tb_dataplane_axi_lite_regs.sv
// tb_dataplane_axi_lite_regs: directed self-checking bench for the dataplane AXI4-Lite register bank
module tb_dataplane_axi_lite_regs;
  logic clk = 0, rst_n = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata, status = 0;
  logic [3:0] wstrb = 0, ctrl;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0, pkt = 0;
  logic [1:0] bresp, rresp;
  int n_cmp = 0, n_err = 0;
  logic [31:0] d, held;
  logic [1:0] r;

  dataplane_axi_lite_regs dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ctrl_o(ctrl), .status_i(status), .pkt_i(pkt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // W is presented lead cycles before AW
  task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                    input int lead, output logic [1:0] resp);
    logic aw_done, w_done, aw_go, w_go;
    aw_done = 0;
    w_done = 0;
    @(negedge clk);
    wdata = dat; wstrb = s; wvalid = 1; bready = 1;
    for (int k = 0; k < 60 && !(aw_done && w_done); k++) begin
      if (k == lead) begin
        awaddr = a;
        awvalid = 1;
        if (lead > 0) chk("bvalid_before_aw", 32'(bvalid), 0);
      end
      aw_go = awvalid && awready;
      w_go = wvalid && wready;
      @(negedge clk);
      if (aw_go) begin awvalid = 0; aw_done = 1; end
      if (w_go) begin wvalid = 0; w_done = 1; end
    end
    for (int k = 0; k < 20 && !bvalid; k++) @(negedge clk);
    chk("wr_bvalid", 32'(bvalid), 1);
    resp = bresp;
    @(negedge clk);
    chk("wr_bvalid_single", 32'(bvalid), 0);
    bready = 0; awvalid = 0; wvalid = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] resp);
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    for (int k = 0; k < 20 && !arready; k++) @(negedge clk);
    @(negedge clk);
    arvalid = 0;
    for (int k = 0; k < 20 && !rvalid; k++) @(negedge clk);
    chk("rd_rvalid", 32'(rvalid), 1);
    dat = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ctrl", 32'(ctrl), 0);
    rst_n = 1;
    @(negedge clk);
    chk("rdy_after_rst", {29'd0, awready, wready, arready}, 32'h7);

    wr(32'hFFFF_FFFF, 32'hAAAA_AAAA, 4'hF, 0, r);
    chk("scr_bresp", 32'(r), 0);
    repeat (10) @(negedge clk);
    rd(32'hFFFF_FFFF, d, r);
    chk("scr_rdata", d, 32'hAAAA_AAAA);
    chk("scr_rresp", 32'(r), 0);

    wr(32'h4, 32'h0000_000F, 4'hF, 5, r);
    chk("ctrl_bresp", 32'(r), 0);
    chk("ctrl_o", 32'(ctrl), 32'hF);
    rd(32'h4, d, r);
    chk("ctrl_rd", d, 32'hF);

    wr(32'hFFFF_FFFC, 32'h1122_3344, 4'hF, 0, r);
    wr(32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b0010, 0, r);
    rd(32'hFFFF_FFFC, d, r);
    chk("scr_strb", d, 32'h1122_FF44);

    wr(32'h0, 32'h1234_5678, 4'hF, 0, r);
    chk("ro_bresp", 32'(r), 0);
    rd(32'h0, d, r);
    chk("id_rd", d, 32'h0001_0000);

    status = 32'hCAFE_F00D;
    rd(32'h8, d, r);
    chk("status_rd", d, 32'hCAFE_F00D);

    repeat (3) begin
      @(negedge clk) pkt = 1;
      @(negedge clk) pkt = 0;
    end
    rd(32'hC, d, r);
    chk("rxcnt_3", d, 3);

    // clear commits on the same edge as a pkt_i pulse
    @(negedge clk);
    awaddr = 32'h4; wdata = 32'h8000_000F; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; pkt = 1;
    @(negedge clk);
    pkt = 0;
    chk("clr_bvalid", 32'(bvalid), 1);
    chk("clr_bresp", 32'(bresp), 0);
    @(negedge clk);
    bready = 0;
    rd(32'hC, d, r);
    chk("rxcnt_clr_wins", d, 0);
    rd(32'h4, d, r);
    chk("ctrl_bit31_reads0", d, 32'hF);
    @(negedge clk) pkt = 1;
    @(negedge clk) pkt = 0;
    rd(32'hC, d, r);
    chk("rxcnt_after_clr", d, 1);

    rd(32'h40, d, r);
    chk("bad_rdata", d, 32'hDEAD_BEEF);
    chk("bad_rresp", 32'(r), 2);
    wr(32'h40, 32'h0BAD_0BAD, 4'hF, 0, r);
    chk("bad_bresp", 32'(r), 2);
    rd(32'hFFFF_FFFC, d, r);
    chk("scr_untouched", d, 32'h1122_FF44);

    // read and write of SCRATCH on the same edge
    @(negedge clk);
    awaddr = 32'hFFFF_FFFC; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; araddr = 32'hFFFF_FFFC; arvalid = 1; rready = 1;
    @(negedge clk);
    arvalid = 0;
    chk("rw_same_rvalid", 32'(rvalid), 1);
    chk("rw_same_prewrite", rdata, 32'h1122_FF44);
    chk("rw_same_bvalid", 32'(bvalid), 1);
    @(negedge clk);
    rready = 0; bready = 0;
    rd(32'hFFFF_FFFC, d, r);
    chk("rw_same_after", d, 32'h5555_5555);

    // backpressure on R then reset mid-read
    @(negedge clk);
    araddr = 32'hFFFF_FFFC; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    held = rdata;
    chk("bp_first", held, 32'h5555_5555);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_rvalid", 32'(rvalid), 1);
      chk("bp_rdata", rdata, held);
      chk("bp_arready", 32'(arready), 0);
    end
    #2 rst_n = 0;
    @(posedge clk);
    #1;
    chk("rst_mid_rvalid", 32'(rvalid), 0);
    chk("rst_mid_ctrl", 32'(ctrl), 0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    chk("rst_mid_arready", 32'(arready), 1);
    rd(32'hFFFF_FFFC, d, r);
    chk("rst_mid_scratch", d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
